rx_uart_128: RTL

// - Serial receiver paired with the 128-bit transmitter: rebuilds a 128-bit word from 16 consecutive 8N1 UART frames on u_rx.
// - Sits downstream of the transmitter's u_tx line (loopback or off-chip); presents data_out with a one-cycle u_rx_done strobe.
// - Byte order matches the transmitter: first byte received -> data_out[127:120]; bits within a byte arrive LSB first.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 rtl/rx_uart_128.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 128-bit UART receiver: frame FSM encoding and defaults.
// The PARITY state exists only when RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef RX_PARITY_EN
    StParity,
`endif
    StStop
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned NUM_BYTES_DEF    = 16;
  localparam int unsigned IDLE_TO_BITS_DEF = 32;

  // Width of a byte index able to hold 0..n.
  function automatic int unsigned byte_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-frame UART receiver: input synchroniser plus start/data/(parity)/stop FSM.
// Build option RX_PARITY_EN adds an even-parity bit between bit 7 and stop.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic [7:0] byte_data_o,
  output logic       idle_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e     state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tick;

  assign tick         = (cnt_q == BitLast);
  assign byte_data_o  = shreg_q;
  assign idle_o       = (state_q == StIdle);

  // Synchroniser flops preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_valid_o = 1'b0;
    byte_err_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en_i && rx_prev_q && !rx_sync_q) begin
          state_d = StStart;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (tick) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (tick) begin
          cnt_d = '0;
          if (^{shreg_q, rx_sync_q}) begin
            byte_err_o = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          cnt_d        = '0;
          state_d      = StIdle;
          byte_valid_o = rx_sync_q;
          byte_err_o   = !rx_sync_q;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en_i) begin
      state_d      = StIdle;
      cnt_d        = '0;
      byte_valid_o = 1'b0;
      byte_err_o   = 1'b0;
    end
  end

endmodule

// File: rtl/rx_uart_128.sv
// 128-bit UART receiver: assembles NUM_BYTES frames (first byte -> MSB) into data_out.
// Build option RX_PARITY_EN enables per-frame even parity in uart_rx_byte.
module rx_uart_128
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned NUM_BYTES    = NUM_BYTES_DEF,
  parameter int unsigned IDLE_TO_BITS = IDLE_TO_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_rx,
  input  logic                   u_rx,
  output logic [8*NUM_BYTES-1:0] data_out,
  output logic                   u_rx_done,
  output logic                   u_rx_err
);

  localparam int unsigned DataW     = 8 * NUM_BYTES;
  localparam int unsigned IdxW      = byte_cnt_width(NUM_BYTES);
  localparam int unsigned IdleLimit = IDLE_TO_BITS * CLKS_PER_BIT;
  localparam int unsigned IdleW     = $clog2(IdleLimit + 1);

  logic             byte_valid, byte_err, line_idle;
  logic [7:0]       byte_data;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [DataW-1:0] word_q, word_d, data_q, data_d;
  logic             done_q, done_d, err_q, err_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_rx),
    .rx_i        (u_rx),
    .byte_valid_o(byte_valid),
    .byte_err_o  (byte_err),
    .byte_data_o (byte_data),
    .idle_o      (line_idle)
  );

  assign data_out  = data_q;
  assign u_rx_done = done_q;
  assign u_rx_err  = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      idle_cnt_q <= '0;
      word_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      idle_cnt_q <= idle_cnt_d;
      word_q     <= word_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    idle_cnt_d = '0;
    word_d     = word_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (!en_rx) begin
      idx_d = '0;
    end else if (byte_err) begin
      idx_d = '0;
      err_d = 1'b1;
    end else if (byte_valid) begin
      word_d = {word_q[DataW-9:0], byte_data};
      if (idx_q == IdxW'(NUM_BYTES - 1)) begin
        data_d = word_d;
        done_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (line_idle && (idx_q != '0)) begin
      // Inter-frame gap inside a word: abort once the idle budget is used up.
      if (idle_cnt_q == IdleW'(IdleLimit - 1)) begin
        err_d = 1'b1;
        idx_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

endmodule
